// File: rtl/avl_ram_slave.sv
// Avalon-MM slave backed by a byte-writable word RAM with a fixed-latency read pipeline.
// Optional random waitrequest stalls are enabled by defining AVL_RAM_SLAVE_STALL_EN.
module avl_ram_slave #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] avl_s0_address,
  input  logic [3:0]  avl_s0_byte_enable,
  input  logic        avl_s0_read,
  input  logic        avl_s0_write,
  input  logic [31:0] avl_s0_write_data,
  output logic        avl_s0_waitrequest,
  output logic [31:0] avl_s0_read_data,
  output logic        avl_s0_read_data_valid,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a command is accepted on any rising edge where (read | write) is high
  // and waitrequest is low; the master must hold the command stable while waitrequest is high.

  logic [31:0]             mem [DEPTH_WORDS];
  logic [AW-1:0]           word_idx;
  logic                    in_range;
  logic                    cmd_acc;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    err_cmd;
  logic [31:0]             rd_word;

  logic                    waitreq_q, waitreq_d;
  logic                    bus_err_q, bus_err_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             rdata_q [READ_LATENCY];
  logic [31:0]             rdata_d [READ_LATENCY];

  assign word_idx = avl_s0_address[AW+1:2];
  assign in_range = (avl_s0_address >> (AW + 2)) == 32'd0;
  assign cmd_acc  = (avl_s0_read | avl_s0_write) & ~waitreq_q;
  assign wr_acc   = cmd_acc & avl_s0_write;
  // A simultaneous read+write is served as the write alone.
  assign rd_acc   = cmd_acc & avl_s0_read & ~avl_s0_write;
  assign err_cmd  = cmd_acc & ((avl_s0_read & avl_s0_write) | ~in_range);
  assign rd_word  = in_range ? mem[word_idx] : 32'd0;

`ifdef AVL_RAM_SLAVE_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) lfsr_q <= 8'hA5;
    else      lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
`ifdef AVL_RAM_SLAVE_STALL_EN
    waitreq_d = (lfsr_d[1:0] == 2'b00);
`else
    waitreq_d = 1'b0;
`endif
    bus_err_d = bus_err_q | err_cmd;
  end

  // Each data stage loads only behind a valid, so the output holds its last response.
  always_comb begin
    vld_d      = '0;
    rdata_d    = rdata_q;
    vld_d[0]   = rd_acc;
    if (rd_acc) rdata_d[0] = rd_word;
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) rdata_d[k] = rdata_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      waitreq_q <= 1'b1;
      bus_err_q <= 1'b0;
      vld_q     <= '0;
      for (int k = 0; k < READ_LATENCY; k++) rdata_q[k] <= 32'd0;
    end else begin
      waitreq_q <= waitreq_d;
      bus_err_q <= bus_err_d;
      vld_q     <= vld_d;
      for (int k = 0; k < READ_LATENCY; k++) rdata_q[k] <= rdata_d[k];
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (avl_s0_byte_enable[b]) mem[word_idx][8*b +: 8] <= avl_s0_write_data[8*b +: 8];
      end
    end
  end

  assign avl_s0_waitrequest     = waitreq_q;
  assign avl_s0_read_data       = rdata_q[READ_LATENCY-1];
  assign avl_s0_read_data_valid = vld_q[READ_LATENCY-1];
  assign bus_err                = bus_err_q;

endmodule

// File: tb/tb_avl_ram_slave.sv
// Scoreboard bench for avl_ram_slave: driver tasks push expected read data and arrival cycle,
// a negedge monitor pops and compares every valid response.
module tb_avl_ram_slave;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic [31:0] address = '0;
  logic [3:0]  byte_enable = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] write_data = '0;
  logic        waitreq;
  logic [31:0] read_data;
  logic        read_valid;
  logic        bus_err;

  avl_ram_slave #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk                    (clk),
    .rest                   (rest),
    .avl_s0_address         (address),
    .avl_s0_byte_enable     (byte_enable),
    .avl_s0_read            (rd),
    .avl_s0_write           (wr),
    .avl_s0_write_data      (write_data),
    .avl_s0_waitrequest     (waitreq),
    .avl_s0_read_data       (read_data),
    .avl_s0_read_data_valid (read_valid),
    .bus_err                (bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        count_en = 1'b0;
  int          stall_cycles = 0;
  int          total_cycles = 0;
  logic [31:0] mon_exp;
  int          mon_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (count_en) begin
      total_cycles++;
      if (waitreq) stall_cycles++;
    end
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got response 0x%08h at cycle %0d, want none", read_data, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("read_data", read_data, mon_exp);
        check("read_latency_cycle", cyc, mon_cyc);
      end
    end
  end

  // driver tasks: start and end on a falling edge
  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic push, input logic [31:0] exp);
    logic stalled;
    int   guard;
    rd = r; wr = w; address = a; write_data = d; byte_enable = be;
    guard = 0;
    forever begin
      stalled = waitreq;
      if (!stalled && push) begin
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + LAT);
      end
      @(posedge clk);
      if (!stalled) break;
      guard++;
      if (guard > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got waitrequest 1 for %0d cycles, want accept", guard);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] ref_mem [64];

  initial begin
    @(negedge clk);
    check("reset_waitrequest", {31'd0, waitreq}, 32'd1);
    check("reset_read_data", read_data, 32'd0);
    check("reset_valid", {31'd0, read_valid}, 32'd0);
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    rest = 1'b0;
    @(negedge clk);
`ifndef AVL_RAM_SLAVE_STALL_EN
    check("release_waitrequest", {31'd0, waitreq}, 32'd0);
`endif

    // full-word write then read
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF);
    idle();
    drain();
    check("bus_err_clean", {31'd0, bus_err}, 32'd0);

    // byte-lane merge and empty byte enable
    issue(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'd0);
    issue(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'd0);
    issue(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b1, 32'h11BB33DD);
    issue(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0);
    issue(1'b1, 1'b0, 32'h23, 32'd0, 4'h0, 1'b1, 32'h11BB33DD);
    idle();
    drain();

    // back-to-back reads, in order with no bubbles
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 32'(i * 4), 32'(i * 4), 4'hF, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 32'(i * 4), 32'd0, 4'h0, 1'b1, 32'(i * 4));
    idle();
    drain();
    check("bus_err_still_clean", {31'd0, bus_err}, 32'd0);

    // simultaneous read+write: write only, no response, error flagged
    issue(1'b1, 1'b1, 32'h0, 32'h5A5A0F0F, 4'hF, 1'b0, 32'd0);
    idle();
    repeat (4) @(negedge clk);
    check("bus_err_rw", {31'd0, bus_err}, 32'd1);
    issue(1'b1, 1'b0, 32'h0, 32'd0, 4'h0, 1'b1, 32'h5A5A0F0F);
    idle();
    drain();

    // reset one cycle after an accepted read drops the response
    issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 32'd0);
    rest = 1'b1; rd = 1'b0; wr = 1'b0;
    #1;
    check("midreset_waitrequest", {31'd0, waitreq}, 32'd1);
    check("midreset_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    check("midreset_valid", {31'd0, read_valid}, 32'd0);
    check("midreset_read_data", read_data, 32'd0);
    rest = 1'b0;
    @(negedge clk);
`ifndef AVL_RAM_SLAVE_STALL_EN
    check("rerelease_waitrequest", {31'd0, waitreq}, 32'd0);
`endif
    repeat (4) @(negedge clk);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF);
    idle();
    drain();
    check("read_data_hold", read_data, 32'hDEADBEEF);

    // out-of-range accesses
    issue(1'b1, 1'b0, 32'(4 * DEPTH), 32'd0, 4'h0, 1'b1, 32'd0);
    idle();
    drain();
    check("bus_err_oob", {31'd0, bus_err}, 32'd1);
    issue(1'b0, 1'b1, 32'(4 * DEPTH + 32'h10), 32'h0BAD0BAD, 4'hF, 1'b0, 32'd0);
    issue(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF);
    idle();
    drain();
    repeat (5) @(negedge clk);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

`ifdef AVL_RAM_SLAVE_STALL_EN
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      issue(1'b0, 1'b1, 32'(i * 4), ref_mem[i], 4'hF, 1'b0, 32'd0);
    end
    count_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int          w;
      logic [31:0] d;
      logic [3:0]  be;
      w = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        be = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        issue(1'b0, 1'b1, 32'(w * 4), d, be, 1'b0, 32'd0);
      end else begin
        issue(1'b1, 1'b0, 32'(w * 4), 32'd0, 4'h0, 1'b1, ref_mem[w]);
      end
    end
    count_en = 1'b0;
    idle();
    drain();
    n_tests++;
    if (stall_cycles * 100 < total_cycles * 15 || stall_cycles * 100 > total_cycles * 35) begin
      n_fail++;
      $display("FAIL stall_ratio: got %0d of %0d cycles stalled, want about 25%%", stall_cycles, total_cycles);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
